// File: rtl/oam_dma_sequencer.sv
// Sprite DMA sequencer: on a CPU write to the DMA register it halts the CPU and
// copies one 256-byte page into PPU OAM as get/put-aligned read/write pairs.
module oam_dma_sequencer #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter int unsigned XFER_LEN     = 256
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        ENABLE,
    input  logic [15:0] CPU_ADDR,
    input  logic [7:0]  CPU_DATA_OUT,
    input  logic        CPU_RW_n,
    input  logic [7:0]  RD_DATA,
    input  logic [7:0]  OAM_BASE,
    output logic        CPU_RDY,
    output logic        BUS_OWN,
    output logic [15:0] DMA_ADDR,
    output logic        DMA_RDEN,
    output logic        OAM_WREN,
    output logic [7:0]  OAM_ADDR,
    output logic [7:0]  OAM_WDATA,
    output logic        BUSY
);

    localparam int unsigned IDX_W = 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              parity_q;
    logic [7:0]        page_q, page_d;
    logic [7:0]        base_q, base_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [15:0]       dma_addr_q, dma_addr_d;
    logic [7:0]        oam_addr_q, oam_addr_d;
    logic [7:0]        oam_wdata_q, oam_wdata_d;
    logic              cpu_rdy_q, cpu_rdy_d;
    logic              bus_own_q, bus_own_d;
    logic              busy_q, busy_d;
    logic              rden_q, rden_d;
    logic              wren_q, wren_d;

    // Next-state, datapath and next-output decode
    always_comb begin
        state_d     = state_q;
        page_d      = page_q;
        base_d      = base_q;
        idx_d       = idx_q;
        dma_addr_d  = dma_addr_q;
        oam_addr_d  = oam_addr_q;
        oam_wdata_d = oam_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (!CPU_RW_n && (CPU_ADDR == DMA_REG_ADDR)) begin
                    state_d = S_HALT;
                    page_d  = CPU_DATA_OUT;
                    base_d  = OAM_BASE;
                    idx_d   = '0;
                end
            end
            S_HALT: begin
                // CPU only halts on a read; the following cycle must be a get to start reading
                if (CPU_RW_n) begin
                    state_d = parity_q ? S_READ : S_ALIGN;
                end
            end
            S_ALIGN: state_d = S_READ;
            S_READ: begin
                state_d     = S_WRITE;
                oam_wdata_d = RD_DATA;
                oam_addr_d  = base_q + idx_q;
            end
            S_WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_READ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_READ) begin
            dma_addr_d = {page_d, idx_d};
        end

        busy_d    = (state_d == S_HALT) || (state_d == S_ALIGN) ||
                    (state_d == S_READ) || (state_d == S_WRITE);
        bus_own_d = (state_d == S_ALIGN) || (state_d == S_READ) || (state_d == S_WRITE);
        cpu_rdy_d = !busy_d;
        rden_d    = (state_d == S_READ);
        wren_d    = (state_d == S_WRITE);
    end

    // State, parity and registered outputs; everything freezes while ENABLE is low
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q     <= S_IDLE;
            parity_q    <= 1'b0;
            page_q      <= '0;
            base_q      <= '0;
            idx_q       <= '0;
            dma_addr_q  <= '0;
            oam_addr_q  <= '0;
            oam_wdata_q <= '0;
            cpu_rdy_q   <= 1'b1;
            bus_own_q   <= 1'b0;
            busy_q      <= 1'b0;
            rden_q      <= 1'b0;
            wren_q      <= 1'b0;
        end else if (ENABLE) begin
            state_q     <= state_d;
            parity_q    <= ~parity_q;
            page_q      <= page_d;
            base_q      <= base_d;
            idx_q       <= idx_d;
            dma_addr_q  <= dma_addr_d;
            oam_addr_q  <= oam_addr_d;
            oam_wdata_q <= oam_wdata_d;
            cpu_rdy_q   <= cpu_rdy_d;
            bus_own_q   <= bus_own_d;
            busy_q      <= busy_d;
            rden_q      <= rden_d;
            wren_q      <= wren_d;
        end
    end

    assign CPU_RDY   = cpu_rdy_q;
    assign BUS_OWN   = bus_own_q;
    assign BUSY      = busy_q;
    assign DMA_ADDR  = dma_addr_q;
    assign OAM_ADDR  = oam_addr_q;
    assign OAM_WDATA = oam_wdata_q;
    // Strobes are masked by the clock enable so a stalled cycle never reads or writes
    assign DMA_RDEN  = rden_q & ENABLE;
    assign OAM_WREN  = wren_q & ENABLE;

endmodule

// File: tb/tb_oam_dma_sequencer.sv
// Directed bench for oam_dma_sequencer: page copies with get/put alignment,
// RMW halt stretch, address wrap, clock-enable stalls and mid-transfer reset.
module tb_oam_dma_sequencer;

    logic        CLK;
    logic        RESET_n;
    logic        ENABLE;
    logic [15:0] CPU_ADDR;
    logic [7:0]  CPU_DATA_OUT;
    logic        CPU_RW_n;
    logic [7:0]  RD_DATA;
    logic [7:0]  OAM_BASE;
    logic        CPU_RDY;
    logic        BUS_OWN;
    logic [15:0] DMA_ADDR;
    logic        DMA_RDEN;
    logic        OAM_WREN;
    logic [7:0]  OAM_ADDR;
    logic [7:0]  OAM_WDATA;
    logic        BUSY;

    oam_dma_sequencer dut (
        .CLK          (CLK),
        .RESET_n      (RESET_n),
        .ENABLE       (ENABLE),
        .CPU_ADDR     (CPU_ADDR),
        .CPU_DATA_OUT (CPU_DATA_OUT),
        .CPU_RW_n     (CPU_RW_n),
        .RD_DATA      (RD_DATA),
        .OAM_BASE     (OAM_BASE),
        .CPU_RDY      (CPU_RDY),
        .BUS_OWN      (BUS_OWN),
        .DMA_ADDR     (DMA_ADDR),
        .DMA_RDEN     (DMA_RDEN),
        .OAM_WREN     (OAM_WREN),
        .OAM_ADDR     (OAM_ADDR),
        .OAM_WDATA    (OAM_WDATA),
        .BUSY         (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory model: byte at {page,i} is i ^ (page - 2), so page $02 holds i
    assign RD_DATA = DMA_ADDR[7:0] ^ (DMA_ADDR[15:8] - 8'h02);

    int n_tests = 0;
    int n_fail  = 0;

    // Get/put parity model: 0 after reset, toggles on every enabled edge
    logic tb_par;
    always @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) tb_par <= 1'b0;
        else if (ENABLE) tb_par <= ~tb_par;
    end

    logic [7:0] exp_page, exp_base;
    int busy_cnt, rdylow_cnt, halt_cnt, align_cnt, rd_cnt, wr_cnt;
    logic [7:0]  last_oam;
    logic [15:0] last_dma;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats(input logic [7:0] page, input logic [7:0] base);
        exp_page   = page;
        exp_base   = base;
        busy_cnt   = 0;
        rdylow_cnt = 0;
        halt_cnt   = 0;
        align_cnt  = 0;
        rd_cnt     = 0;
        wr_cnt     = 0;
        last_oam   = 8'h00;
        last_dma   = 16'h0000;
    endtask

    // Mid-cycle observer: counts enabled cycles and checks every strobe
    always @(negedge CLK) begin
        if (RESET_n) begin
            if (!ENABLE) begin
                chk("strobe_while_disabled", 32'({DMA_RDEN, OAM_WREN}), 32'd0);
            end else begin
                if (BUSY) busy_cnt++;
                if (!CPU_RDY) rdylow_cnt++;
                if (BUSY && !BUS_OWN) halt_cnt++;
                if (BUS_OWN && !DMA_RDEN && !OAM_WREN) align_cnt++;
                if (DMA_RDEN) begin
                    chk("rden_parity", 32'(tb_par), 32'd0);
                    chk("dma_addr", 32'(DMA_ADDR), 32'({exp_page, 8'(rd_cnt)}));
                    last_dma = DMA_ADDR;
                    rd_cnt++;
                end
                if (OAM_WREN) begin
                    chk("wren_parity", 32'(tb_par), 32'd1);
                    chk("oam_addr", 32'(OAM_ADDR), 32'(8'(exp_base + 8'(wr_cnt))));
                    chk("oam_wdata", 32'(OAM_WDATA), 32'(8'(wr_cnt) ^ (exp_page - 8'h02)));
                    last_oam = OAM_ADDR;
                    wr_cnt++;
                end
            end
        end
    end

    // Write the DMA register so the first HALT cycle has parity halt_par,
    // then keep the CPU writing for extra_wr more cycles (to $4014 again, which must be ignored)
    task automatic trigger(input logic [7:0] page, input logic [7:0] base,
                           input logic halt_par, input int extra_wr);
        clear_stats(page, base);
        @(posedge CLK); #1;
        if (tb_par == halt_par) begin
            @(posedge CLK); #1;
        end
        CPU_ADDR     = 16'h4014;
        CPU_DATA_OUT = page;
        OAM_BASE     = base;
        CPU_RW_n     = 1'b0;
        for (int k = 0; k < extra_wr; k++) begin
            @(posedge CLK); #1;
            CPU_DATA_OUT = 8'h99;
            OAM_BASE     = 8'h33;
        end
        @(posedge CLK); #1;
        CPU_RW_n = 1'b1;
        CPU_ADDR = 16'h8000;
    endtask

    task automatic wait_done(input int bound, input bit toggle_en);
        int n = 0;
        while (BUSY && n < bound) begin
            @(posedge CLK); #1;
            if (toggle_en) ENABLE = ($urandom_range(0, 3) != 0);
            n++;
        end
        ENABLE = 1'b1;
        chk("done_timeout", 32'(BUSY), 32'd0);
        repeat (2) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic chk_xfer(input string tag, input int exp_busy, input int exp_halt,
                            input int exp_align);
        chk({tag, "_busy"}, 32'(busy_cnt), 32'(exp_busy));
        chk({tag, "_rdy_low"}, 32'(rdylow_cnt), 32'(exp_busy));
        chk({tag, "_halt"}, 32'(halt_cnt), 32'(exp_halt));
        chk({tag, "_align"}, 32'(align_cnt), 32'(exp_align));
        chk({tag, "_reads"}, 32'(rd_cnt), 32'd256);
        chk({tag, "_writes"}, 32'(wr_cnt), 32'd256);
        chk({tag, "_cpu_rdy_after"}, 32'(CPU_RDY), 32'd1);
        chk({tag, "_bus_own_after"}, 32'(BUS_OWN), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        RESET_n      = 1'b0;
        ENABLE       = 1'b1;
        CPU_ADDR     = 16'h8000;
        CPU_DATA_OUT = 8'h00;
        CPU_RW_n     = 1'b1;
        OAM_BASE     = 8'h00;
        clear_stats(8'h00, 8'h00);
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_cpu_rdy", 32'(CPU_RDY), 32'd1);
        chk("rst_bus_own", 32'(BUS_OWN), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_rden", 32'(DMA_RDEN), 32'd0);
        chk("rst_wren", 32'(OAM_WREN), 32'd0);
        chk("rst_dma_addr", 32'(DMA_ADDR), 32'd0);
        chk("rst_oam_addr", 32'(OAM_ADDR), 32'd0);
        chk("rst_oam_wdata", 32'(OAM_WDATA), 32'd0);
        RESET_n = 1'b1;
        repeat (2) begin
            @(posedge CLK); #1;
        end

        // Halt on put: no ALIGN, 513 busy cycles
        trigger(8'h02, 8'h00, 1'b1, 0);
        wait_done(2000, 1'b0);
        chk_xfer("put_halt", 513, 1, 0);

        // Halt on get: one ALIGN cycle, 514 busy cycles
        trigger(8'h02, 8'h00, 1'b0, 0);
        wait_done(2000, 1'b0);
        chk_xfer("get_halt", 514, 1, 1);

        // CPU still writing for two cycles (including ignored $4014 writes): HALT is 3 cycles
        trigger(8'h03, 8'h10, 1'b1, 2);
        wait_done(2000, 1'b0);
        chk_xfer("rmw_halt", 515, 3, 0);

        // Top page and wrapping OAM index
        trigger(8'hFF, 8'hF0, 1'b1, 0);
        wait_done(2000, 1'b0);
        chk_xfer("wrap", 513, 1, 0);
        chk("wrap_last_oam", 32'(last_oam), 32'h0000_00EF);
        chk("wrap_last_dma", 32'(last_dma), 32'h0000_FFFF);

        // Random clock-enable stalls: same results measured in enabled cycles
        trigger(8'h05, 8'h40, 1'b0, 0);
        wait_done(6000, 1'b1);
        chk_xfer("enable_stall", 514, 1, 1);

        // Reset in the middle of a transfer, then a full transfer afterwards
        trigger(8'h02, 8'h00, 1'b1, 0);
        n = 0;
        while (n < 1000) begin
            @(posedge CLK); #2;
            if (OAM_WREN && OAM_ADDR == 8'h80) break;
            n++;
        end
        chk("reset_wait_timeout", 32'(n < 1000), 32'd1);
        RESET_n = 1'b0;
        #1;
        chk("midrst_cpu_rdy", 32'(CPU_RDY), 32'd1);
        chk("midrst_bus_own", 32'(BUS_OWN), 32'd0);
        chk("midrst_busy", 32'(BUSY), 32'd0);
        chk("midrst_wren", 32'(OAM_WREN), 32'd0);
        @(posedge CLK); #3;
        RESET_n = 1'b1;
        trigger(8'h06, 8'h80, 1'b0, 0);
        wait_done(2000, 1'b0);
        chk_xfer("after_reset", 514, 1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
